// File: rtl/game_ctrl_pkg.sv
// Shared types and level-decode helpers for the game control blocks.
// Provides the spawn FSM state type, ball/level limits and decode functions.
package game_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SPAWN,
        S_WAIT_ACK,
        S_WAIT_GAP
    } spawn_state_t;

    localparam int MAX_LEVEL = 12;
    localparam int NUM_BALLS = 3;

    function automatic logic [3:0] clamp_level(input logic [3:0] level);
        return (level > 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : level;
    endfunction

    // Levels cycle 1,2,3 balls; every third level bumps the size.
    function automatic logic [1:0] level_to_need(input logic [3:0] level);
        logic [3:0] l;
        l = clamp_level(level);
        if (l == 4'd0) return 2'd0;
        return 2'((l - 4'd1) % 4'd3 + 4'd1);
    endfunction

    function automatic logic [1:0] level_to_size(input logic [3:0] level);
        logic [3:0] l;
        l = clamp_level(level);
        if (l == 4'd0) return 2'd0;
        return 2'((l - 4'd1) / 4'd3);
    endfunction

    function automatic logic [2:0] slot_onehot(input logic [1:0] slot);
        logic [2:0] oh;
        oh = '0;
        for (int k = 0; k < NUM_BALLS; k++)
            if (slot == 2'(k)) oh[k] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/sec_edge_detect.sv
// Rising-edge pulse generator for a slow square wave (e.g. 1 Hz secClk).
// Ports: clk, reset (async high), sig_i (level input), rise_o (1-cycle pulse).
module sec_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sig_q <= 1'b0;
        else       sig_q <= sig_i;
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/ball_spawn_scheduler.sv
// Sequences ball spawns per level: one slot at a time, ack handshake with
// timeout/retry, and a seconds gap between spawns.
// Ports: clk, reset, enable, level, secClk, ballInUse in; ballActive,
// ballInitialState, busy, errCount out (all registered).
module ball_spawn_scheduler
    import game_ctrl_pkg::*;
#(
    parameter int SPAWN_GAP_SEC = 2,
    parameter int ACK_TIMEOUT   = 16,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [3:0]       level,
    input  logic             secClk,
    input  logic [2:0]       ballInUse,
    output logic [2:0]       ballActive,
    output logic [5:0]       ballInitialState,
    output logic             busy,
    output logic [ERR_W-1:0] errCount
);

    localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int GAP_W = $clog2(SPAWN_GAP_SEC + 1);

    spawn_state_t     state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [3:0]       lvl_q, lvl_d;
    logic [ACK_W-1:0] ack_q, ack_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [2:0]       act_q, act_d;
    logic [5:0]       init_q, init_d;
    logic             busy_q, busy_d;

    logic       sec_tick;
    logic       found;
    logic [1:0] pick;
    logic [1:0] need;
    logic [1:0] size;

    sec_edge_detect u_sec (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (secClk),
        .rise_o (sec_tick)
    );

    assign need = level_to_need(level);
    assign size = level_to_size(lvl_d);

    // Lowest free slot below the level's ball count.
    always_comb begin
        found = 1'b0;
        pick  = 2'd0;
        for (int k = NUM_BALLS - 1; k >= 0; k--) begin
            if (2'(k) < need && !ballInUse[k]) begin
                found = 1'b1;
                pick  = 2'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            lvl_q   <= '0;
            ack_q   <= '0;
            gap_q   <= '0;
            err_q   <= '0;
            act_q   <= '0;
            init_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            lvl_q   <= lvl_d;
            ack_q   <= ack_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
            act_q   <= act_d;
            init_q  <= init_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        lvl_d   = lvl_q;
        ack_d   = ack_q;
        gap_d   = gap_q;
        err_d   = err_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (level != 4'd0) state_d = S_SELECT;
                end
                S_SELECT: begin
                    lvl_d = level;
                    if (found) begin
                        slot_d  = pick;
                        state_d = S_SPAWN;
                    end
                end
                S_SPAWN: begin
                    ack_d   = '0;
                    state_d = S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    // Ack wins over a simultaneous timeout.
                    if ((ballInUse & slot_onehot(slot_q)) != 3'b000) begin
                        gap_d   = '0;
                        state_d = S_WAIT_GAP;
                    end else if (ack_q == ACK_W'(ACK_TIMEOUT - 1)) begin
                        if (err_q != '1) err_d = err_q + ERR_W'(1);
                        state_d = S_SELECT;
                    end else begin
                        ack_d = ack_q + ACK_W'(1);
                    end
                end
                S_WAIT_GAP: begin
                    if (sec_tick) begin
                        gap_d = gap_q + GAP_W'(1);
                        if (gap_d == GAP_W'(SPAWN_GAP_SEC)) state_d = S_SELECT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they align with it.
    always_comb begin
        act_d  = '0;
        init_d = init_q;
        busy_d = (state_d == S_SPAWN) || (state_d == S_WAIT_ACK);
        if (state_d == S_SPAWN && state_q != S_SPAWN) begin
            act_d = slot_onehot(slot_d);
            for (int k = 0; k < NUM_BALLS; k++)
                if (slot_d == 2'(k)) init_d[2*k +: 2] = size;
        end
    end

    assign ballActive       = act_q;
    assign ballInitialState = init_q;
    assign busy             = busy_q;
    assign errCount         = err_q;

endmodule

// File: tb/tb_ball_spawn_scheduler.sv
// Directed self-checking bench for ball_spawn_scheduler.
// Logs every spawn pulse and checks slots, sizes, spacing and error counts.
module tb_ball_spawn_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] level = 4'd0;
    logic       secClk = 1'b0;
    logic       sec_run = 1'b0;
    logic       ack_en = 1'b0;
    logic [2:0] use_man = 3'b000;
    logic [2:0] acked;
    logic [2:0] ballInUse;
    logic [2:0] ballActive;
    logic [5:0] ballInitialState;
    logic       busy;
    logic [3:0] errCount;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ball_spawn_scheduler #(
        .SPAWN_GAP_SEC (2),
        .ACK_TIMEOUT   (16),
        .ERR_W         (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .level            (level),
        .secClk           (secClk),
        .ballInUse        (ballInUse),
        .ballActive       (ballActive),
        .ballInitialState (ballInitialState),
        .busy             (busy),
        .errCount         (errCount)
    );

    // Ball model: a pulsed slot reports alive from the following cycle.
    assign ballInUse = use_man | acked;

    always @(negedge clk or posedge reset) begin
        if (reset || !ack_en) acked <= 3'b000;
        else                  acked <= acked | ballActive;
    end

    // secClk: 20-cycle period while running.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            if (sec_run) begin
                cnt++;
                if (cnt == 10) begin
                    cnt = 0;
                    secClk = ~secClk;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Pulse log.
    int         cyc = 0;
    int         npulse = 0;
    int         nrise = 0;
    int         viol = 0;
    logic       prev_sec = 1'b0;
    logic [2:0] prev_act = 3'b000;
    int         p_cyc  [256];
    int         p_slot [256];
    int         p_rise [256];
    logic [5:0] p_init [256];
    logic [3:0] p_err  [256];

    always @(negedge clk) begin
        cyc      <= cyc + 1;
        prev_sec <= secClk;
        prev_act <= ballActive;
        if (secClk && !prev_sec) nrise <= nrise + 1;
        if (ballActive != 3'b000) begin
            if ($countones(ballActive) != 1 || prev_act != 3'b000)
                viol <= viol + 1;
            p_cyc[npulse]  <= cyc + 1;
            p_slot[npulse] <= ballActive[0] ? 0 : (ballActive[1] ? 1 : 2);
            p_rise[npulse] <= nrise + ((secClk && !prev_sec) ? 1 : 0);
            p_init[npulse] <= ballInitialState;
            p_err[npulse]  <= errCount;
            npulse         <= npulse + 1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_pulses(input string tag, input int target,
                               input int budget);
        for (int i = 0; i < budget && npulse < target; i++) step();
        check(tag, (npulse >= target) ? 1 : 0, 1);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        enable  = 1'b0;
        level   = 4'd0;
        use_man = 3'b000;
        ack_en  = 1'b0;
        sec_run = 1'b0;
        step(2);
        reset = 1'b0;
        step();
    endtask

    initial begin
        int b;
        int c0;

        // Reset state
        do_reset();
        check("rst_act", 32'(ballActive), 0);
        check("rst_init", 32'(ballInitialState), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(errCount), 0);

        // 1: level 1, single spawn two cycles after enable
        b      = npulse;
        c0     = cyc;
        enable = 1'b1;
        level  = 4'd1;
        wait_pulses("t1_pulse", b + 1, 10);
        check("t1_latency", p_cyc[b] - c0, 2);
        check("t1_slot", p_slot[b], 0);
        check("t1_size", 32'(p_init[b][1:0]), 0);
        check("t1_busy_spawn", 32'(busy), 1);
        use_man = 3'b001;
        step();
        check("t1_act_off", 32'(ballActive), 0);
        check("t1_busy_ack", 32'(busy), 1);
        step();
        check("t1_busy_done", 32'(busy), 0);
        sec_run = 1'b1;
        step(80);
        check("t1_no_more", npulse - b, 1);

        // 2: level 6, three spawns of size 1 spaced by two secClk edges
        do_reset();
        b       = npulse;
        ack_en  = 1'b1;
        sec_run = 1'b1;
        level   = 4'd6;
        enable  = 1'b1;
        wait_pulses("t2_pulses", b + 3, 200);
        check("t2_slot0", p_slot[b], 0);
        check("t2_slot1", p_slot[b + 1], 1);
        check("t2_slot2", p_slot[b + 2], 2);
        check("t2_gap01", p_rise[b + 1] - p_rise[b], 2);
        check("t2_gap12", p_rise[b + 2] - p_rise[b + 1], 2);
        step(80);
        check("t2_no_more", npulse - b, 3);
        check("t2_sizes", 32'(ballInitialState), 32'h15);

        // 3: level 12, no ack ever; retries and saturating errors
        do_reset();
        b      = npulse;
        level  = 4'd12;
        enable = 1'b1;
        wait_pulses("t3_pulses", b + 17, 17 * 18 + 20);
        check("t3_slot", p_slot[b + 5], 0);
        check("t3_size", 32'(p_init[b][1:0]), 3);
        check("t3_period_a", p_cyc[b + 1] - p_cyc[b], 18);
        check("t3_period_b", p_cyc[b + 16] - p_cyc[b + 15], 18);
        check("t3_err1", 32'(p_err[b + 1]), 1);
        check("t3_err14", 32'(p_err[b + 14]), 14);
        check("t3_err15", 32'(p_err[b + 15]), 15);
        check("t3_err_sat", 32'(p_err[b + 16]), 15);

        // 4: level change while a spawn awaits its ack
        do_reset();
        b      = npulse;
        level  = 4'd10;
        enable = 1'b1;
        wait_pulses("t4_first", b + 1, 10);
        check("t4_slot0", p_slot[b], 0);
        check("t4_size3", 32'(p_init[b][1:0]), 3);
        step();
        level = 4'd2;
        step(3);
        use_man = 3'b001;
        sec_run = 1'b1;
        wait_pulses("t4_second", b + 2, 150);
        check("t4_slot1", p_slot[b + 1], 1);
        check("t4_init", 32'(p_init[b + 1][3:0]), 32'h3);

        // 5: drop enable in WAIT_GAP, then in SPAWN
        do_reset();
        b      = npulse;
        level  = 4'd4;
        enable = 1'b1;
        wait_pulses("t5_two", b + 2, 60);
        step();
        use_man = 3'b001;
        step(4);
        enable = 1'b0;
        step();
        check("t5_gap_busy", 32'(busy), 0);
        check("t5_gap_act", 32'(ballActive), 0);
        sec_run = 1'b1;
        step(60);
        check("t5_gap_quiet", npulse - b, 2);
        check("t5_gap_err", 32'(errCount), 1);
        check("t5_gap_init", 32'(ballInitialState), 1);
        sec_run = 1'b0;
        use_man = 3'b000;
        level   = 4'd5;
        enable  = 1'b1;
        wait_pulses("t5_spawn", b + 3, 10);
        enable = 1'b0;
        step();
        check("t5_sp_act", 32'(ballActive), 0);
        check("t5_sp_busy", 32'(busy), 0);
        step(40);
        check("t5_sp_quiet", npulse - b, 3);
        check("t5_sp_err", 32'(errCount), 1);

        // 6: async reset mid WAIT_ACK, then clean restart
        do_reset();
        b      = npulse;
        level  = 4'd7;
        enable = 1'b1;
        wait_pulses("t6_two", b + 2, 60);
        step(3);
        #2;
        reset = 1'b1;
        #1;
        check("t6_act", 32'(ballActive), 0);
        check("t6_init", 32'(ballInitialState), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_err", 32'(errCount), 0);
        step();
        reset = 1'b0;
        c0    = cyc;
        wait_pulses("t6_restart", b + 3, 10);
        check("t6_latency", p_cyc[b + 2] - c0, 2);
        check("t6_slot", p_slot[b + 2], 0);
        check("t6_size", 32'(p_init[b + 2][1:0]), 2);

        check("pulse_shape", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ball_spawn_scheduler.md
Name: ball_spawn_scheduler

Overview:
Sequences ball spawning for the active game level. It converts the level number into a ball count and initial ball size. It then issues one-cycle spawn requests to the three ball slots, one slot at a time, spaced by a programmable number of seconds. Each request is a handshake against the slot's in-use flag, with timeout and retry. It sits between the level controller (level, enable) and the three ball objects.

Parameters:
SPAWN_GAP_SEC, 2, whole seconds (secClk rising edges) between a completed spawn and the next selection.
ACK_TIMEOUT, 16, clk cycles to wait for ballInUse[k] to rise after a spawn pulse.
ERR_W, 4, width of the saturating timeout-error counter.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
enable  in  1  game running; low forces IDLE.
level  in  4  current level, 0..15; 0 means no play.
secClk  in  1  1 Hz square wave; rising edge detected internally.
ballInUse  in  3  bit k high while ball slot k is alive.
ballActive  out  3  one-hot, one-cycle spawn pulse for slot k.
ballInitialState  out  6  2 bits per slot ([2k+1:2k]); initial size for slot k.
busy  out  1  high in SPAWN or WAIT_ACK.
errCount  out  ERR_W  saturating count of handshake timeouts.

Behaviour:
- Interface: one clock (clk); reset is asynchronous, active-high. All outputs are registered.
- Reset values: state=IDLE, ballActive=0, ballInitialState=0, busy=0, errCount=0, gap/ack counters=0, secClk sample register=0.
- secTick is high for one cycle when the registered secClk is 0 and the current secClk is 1.
- Level decode (levels above 12 clamp to 12):
  - need = ((L-1) mod 3)+1 balls, using slots 0..need-1.
  - size = (L-1) div 3, giving 0..3.
  - L=0 gives need=0.
- States: IDLE, SELECT, SPAWN, WAIT_ACK, WAIT_GAP.
- IDLE:
  - When enable=1 and level!=0, go to SELECT on the next cycle. There is no gap before the first spawn.
  - Otherwise stay in IDLE.
- SELECT:
  - Sample level into levelReg.
  - Pick the lowest k < need with ballInUse[k]=0.
  - If a slot is found, latch it as curSlot and go to SPAWN.
  - If none is found, stay in SELECT and re-evaluate every cycle.
- SPAWN (exactly 1 cycle):
  - ballActive[curSlot]=1 and busy=1.
  - ballInitialState[curSlot] is written with size. The other slot fields hold their values.
  - ackCnt is cleared, then go to WAIT_ACK.
- WAIT_ACK:
  - If ballInUse[curSlot]=1, go to WAIT_GAP with gapCnt=0.
  - Else if ackCnt==ACK_TIMEOUT-1, increment errCount (saturating at all-ones) and go to SELECT to retry.
  - Otherwise increment ackCnt.
  - An ack and a timeout in the same cycle count as an ack.
- WAIT_GAP:
  - gapCnt increments on each secTick.
  - When gapCnt reaches SPAWN_GAP_SEC, go to SELECT.
  - A secTick in the cycle the FSM enters WAIT_GAP is not counted.
- enable=0 in any state: the next state is IDLE and ballActive is 0 from the next cycle. ballInitialState and errCount hold their values.
- A level change mid-operation takes effect only at the next SELECT. The spawn in flight completes with its latched size.
- Slots at or above need are never spawned. Balls already alive in such slots after a level decrease are left alone.
- Reset asserted mid-operation returns everything to the reset values immediately (asynchronously).
- ballActive is never multi-hot and never pulses for two consecutive cycles.

Decomposition:
- Package game_ctrl_pkg:
  - spawn_state_t enum.
  - MAX_LEVEL=12 and NUM_BALLS=3.
  - Functions level_to_need(level) and level_to_size(level).
- One sub-module, sec_edge_detect: registered rising-edge pulse generator for secClk, reusable by other timers.
- The FSM and counters stay in ball_spawn_scheduler.

Test Plan:
1. Reset, then enable=1, level=1, ballInUse=000. Expect ballActive=001 exactly 2 cycles after enable, ballInitialState[1:0]=0, then busy for 1 cycle. Raise ballInUse[0] in the next cycle; no further spawns.
2. level=6, all slots free, ack returned 1 cycle after each pulse. Expect spawns on slots 0, 1, 2 in order, each with size=1. Spawns are separated by exactly 2 secClk rising edges.
3. level=12, ballInUse never rises. Expect a retry pulse every ACK_TIMEOUT+2 cycles. errCount increments each timeout and saturates at 15 after 15 timeouts.
4. level=10 with a slot-0 spawn in WAIT_ACK; change level to 2. The in-flight spawn keeps size=3. The next spawn uses slot 1 with size=0.
5. Drop enable during WAIT_GAP and during SPAWN. Expect IDLE next cycle, no ballActive pulse after that, and errCount unchanged.
6. Assert reset asynchronously mid-WAIT_ACK, between clk edges. Expect all outputs 0 immediately, and a clean restart after release.
